// File: rtl/egg_timer_ctrl.sv
// Egg-timer sequencing: keypad MM:SS entry, load/clear strobes, 1 Hz decrement enable, alarm at 00:00.
// Build option: define EGG_ALARM_TIMEOUT_EN to auto-clear the alarm after ALARM_TICKS ticks.
//
// state | meaning
// IDLE  | accepting keypad digits, waiting for start
// LOAD  | wrtEn pulse copies the entry into the countdown register
// RUN   | prescaler ticking, decEn pulses, watching for 00:00
// PAUSE | prescaler frozen, waiting for start to resume
// ALARM | alarm asserted, waiting for start/stop (or timeout)
// CLR   | wrtEn pulse with a zero entry to clear the countdown register
module egg_timer_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digitIn,
  input  logic        digitValid,
  input  logic        startBtn,
  input  logic        stopBtn,
  input  logic        clearBtn,
  input  logic [3:0]  secOnes,
  input  logic [3:0]  secTens,
  input  logic [3:0]  minOnes,
  input  logic [3:0]  minTens,
  output logic [15:0] minsSecsOut,
  output logic        wrtEn,
  output logic        decEn,
  output logic        alarm,
  output logic        err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_ALARM = 3'd4,
    S_CLR   = 3'd5
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || ALARM_TICKS < 1) begin : g_bad_param
    $error("egg_timer_ctrl: TICK_DIV must be >= 2 and ALARM_TICKS >= 1");
  end

  state_t         state_q;
  logic [15:0]    entry_q;
  logic [PW-1:0]  presc_q;
  logic [PW-1:0]  presc_d;
  logic           err_q;
  logic           tick;
  logic           count_zero;
  logic           entry_ok;

`ifdef EGG_ALARM_TIMEOUT_EN
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  logic [AW-1:0]  alarm_cnt_q;
`endif

  assign tick       = (presc_q == PRESC_MAX);
  assign presc_d    = tick ? '0 : presc_q + PW'(1);
  assign count_zero = ({minTens, minOnes, secTens, secOnes} == 16'h0000);

  // Nibbles can only hold 0..9 via the keypad filter, but a start must still reject seconds >= 60.
  assign entry_ok = (entry_q != 16'h0000) &&
                    (entry_q[15:12] <= 4'd9) && (entry_q[11:8] <= 4'd9) &&
                    (entry_q[7:4]   <= 4'd5) && (entry_q[3:0]  <= 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      presc_q <= '0;
      err_q   <= 1'b0;
`ifdef EGG_ALARM_TIMEOUT_EN
      alarm_cnt_q <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      if (clearBtn) begin
        state_q <= S_CLR;
        entry_q <= '0;
        presc_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (startBtn) begin
              if (entry_ok) state_q <= S_LOAD;
              else          err_q   <= 1'b1;
            end else if (!stopBtn && digitValid && (digitIn <= 4'd9)) begin
              entry_q <= {entry_q[11:0], digitIn};
            end
          end
          S_LOAD: begin
            state_q <= S_RUN;
            presc_q <= '0;
          end
          S_RUN: begin
            // Restart the prescaler on the way into ALARM so the alarm timeout is a whole number of ticks.
            if (count_zero) begin
              state_q <= S_ALARM;
              presc_q <= '0;
`ifdef EGG_ALARM_TIMEOUT_EN
              alarm_cnt_q <= '0;
`endif
            end else begin
              presc_q <= presc_d;
              if (stopBtn) state_q <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (startBtn) state_q <= S_RUN;
          end
          S_ALARM: begin
            presc_q <= presc_d;
`ifdef EGG_ALARM_TIMEOUT_EN
            if (tick) alarm_cnt_q <= alarm_cnt_q + AW'(1);
            if (startBtn || stopBtn || (tick && alarm_cnt_q == ALARM_LAST)) state_q <= S_IDLE;
`else
            if (startBtn || stopBtn) state_q <= S_IDLE;
`endif
          end
          S_CLR: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign minsSecsOut = entry_q;
  assign wrtEn       = (state_q == S_LOAD) || (state_q == S_CLR);
  assign decEn       = (state_q == S_RUN) && !count_zero && tick;
  assign alarm       = (state_q == S_ALARM);
  assign err         = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl with a behavioural BCD countdown register closing the feedback loop.
module tb_egg_timer_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int ALARM_TICKS = 3;
`ifdef EGG_ALARM_TIMEOUT_EN
  localparam int EXP_ALARM_CYC = 12;
`else
  localparam int EXP_ALARM_CYC = 100;
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_ALARM = 3'd4;
  localparam logic [2:0] ST_CLR   = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digitIn;
  logic        digitValid, startBtn, stopBtn, clearBtn;
  logic [15:0] cnt_q;
  logic [15:0] minsSecsOut;
  logic        wrtEn, decEn, alarm, err;
  logic [2:0]  state;

  always #5 clk = ~clk;

  egg_timer_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk), .reset(reset),
    .digitIn(digitIn), .digitValid(digitValid),
    .startBtn(startBtn), .stopBtn(stopBtn), .clearBtn(clearBtn),
    .secOnes(cnt_q[3:0]), .secTens(cnt_q[7:4]), .minOnes(cnt_q[11:8]), .minTens(cnt_q[15:12]),
    .minsSecsOut(minsSecsOut), .wrtEn(wrtEn), .decEn(decEn),
    .alarm(alarm), .err(err), .state(state)
  );

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] so, st, mo, mt;
    {mt, mo, st, so} = v;
    if (so != 0) so = so - 1;
    else begin
      so = 9;
      if (st != 0) st = st - 1;
      else begin
        st = 5;
        if (mo != 0) mo = mo - 1;
        else begin
          mo = 9;
          if (mt != 0) mt = mt - 1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // Downstream countdown register model
  always @(posedge clk) begin
    if (reset)      cnt_q <= 16'h0000;
    else if (wrtEn) cnt_q <= minsSecsOut;
    else if (decEn) cnt_q <= bcd_dec(cnt_q);
  end

  typedef struct {
    string       nm;
    logic        clr, start, stop, dv;
    logic [3:0]  dig;
    logic [2:0]  st;
    logic [15:0] mss;
    logic        wrt, dec, alm, er;
  } vec_t;

  typedef struct {
    string       nm;
    logic [2:0]  st;
    logic [15:0] mss;
    logic        wrt, dec, alm, er;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic drive(input logic clr, input logic st, input logic sp, input logic dv, input logic [3:0] d);
    clearBtn = clr; startBtn = st; stopBtn = sp; digitValid = dv; digitIn = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic clr, input logic st, input logic sp, input logic dv,
                     input logic [3:0] d, input logic [2:0] est, input logic [15:0] emss,
                     input logic ewrt, input logic edec, input logic ealm, input logic eerr);
    vec_t v;
    v.nm = nm; v.clr = clr; v.start = st; v.stop = sp; v.dv = dv; v.dig = d;
    v.st = est; v.mss = emss; v.wrt = ewrt; v.dec = edec; v.alm = ealm; v.er = eerr;
    tbl.push_back(v);
  endtask

  initial begin
    exp_t e;
    int dec1, dec2, ndec, alm_at, alm_cyc, pdec, rdec;

    reset = 1'b1;
    drive(0, 0, 0, 0, 4'd0);

    //   name      clr st sp dv dig    state     mss      wrt dec alm err
    add("d0",      0, 0, 0, 1, 4'd0,  ST_IDLE,  16'h0000, 0, 0, 0, 0);
    add("d1",      0, 0, 0, 1, 4'd1,  ST_IDLE,  16'h0001, 0, 0, 0, 0);
    add("d12",     0, 0, 0, 1, 4'd12, ST_IDLE,  16'h0001, 0, 0, 0, 0);
    add("d3",      0, 0, 0, 1, 4'd3,  ST_IDLE,  16'h0013, 0, 0, 0, 0);
    add("d0b",     0, 0, 0, 1, 4'd0,  ST_IDLE,  16'h0130, 0, 0, 0, 0);
    add("start",   0, 1, 0, 0, 4'd0,  ST_LOAD,  16'h0130, 1, 0, 0, 0);
    add("run0",    0, 0, 0, 0, 4'd0,  ST_RUN,   16'h0130, 0, 0, 0, 0);
    add("run1dig", 0, 0, 0, 1, 4'd5,  ST_RUN,   16'h0130, 0, 0, 0, 0);
    add("run2st",  0, 1, 0, 0, 4'd0,  ST_RUN,   16'h0130, 0, 0, 0, 0);
    add("run3",    0, 0, 0, 0, 4'd0,  ST_RUN,   16'h0130, 0, 1, 0, 0);
    add("run4",    0, 0, 0, 0, 4'd0,  ST_RUN,   16'h0130, 0, 0, 0, 0);
    add("run5",    0, 0, 0, 0, 4'd0,  ST_RUN,   16'h0130, 0, 0, 0, 0);
    add("run6",    0, 0, 0, 0, 4'd0,  ST_RUN,   16'h0130, 0, 0, 0, 0);
    add("run7",    0, 0, 0, 0, 4'd0,  ST_RUN,   16'h0130, 0, 1, 0, 0);
    add("clr",     1, 0, 0, 0, 4'd0,  ST_CLR,   16'h0000, 1, 0, 0, 0);
    add("clridle", 0, 0, 0, 0, 4'd0,  ST_IDLE,  16'h0000, 0, 0, 0, 0);
    add("dig12",   0, 0, 0, 1, 4'd12, ST_IDLE,  16'h0000, 0, 0, 0, 0);
    add("e0",      0, 0, 0, 1, 4'd0,  ST_IDLE,  16'h0000, 0, 0, 0, 0);
    add("e7",      0, 0, 0, 1, 4'd7,  ST_IDLE,  16'h0007, 0, 0, 0, 0);
    add("e5",      0, 0, 0, 1, 4'd5,  ST_IDLE,  16'h0075, 0, 0, 0, 0);
    add("bad75",   0, 1, 0, 0, 4'd0,  ST_IDLE,  16'h0075, 0, 0, 0, 1);
    add("bad75b",  0, 0, 0, 0, 4'd0,  ST_IDLE,  16'h0075, 0, 0, 0, 0);
    add("clr2",    1, 0, 0, 0, 4'd0,  ST_CLR,   16'h0000, 1, 0, 0, 0);
    add("clr2i",   0, 0, 0, 0, 4'd0,  ST_IDLE,  16'h0000, 0, 0, 0, 0);
    add("bad00",   0, 1, 0, 0, 4'd0,  ST_IDLE,  16'h0000, 0, 0, 0, 1);
    add("bad00b",  0, 0, 0, 0, 4'd0,  ST_IDLE,  16'h0000, 0, 0, 0, 0);

    step();
    step();
    chk("rst_state", state, ST_IDLE);
    chk("rst_mss", minsSecsOut, 16'h0000);
    chk("rst_wrt", wrtEn, 1'b0);
    chk("rst_dec", decEn, 1'b0);
    chk("rst_alarm", alarm, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].start, tbl[i].stop, tbl[i].dv, tbl[i].dig);
      e.nm = tbl[i].nm; e.st = tbl[i].st; e.mss = tbl[i].mss;
      e.wrt = tbl[i].wrt; e.dec = tbl[i].dec; e.alm = tbl[i].alm; e.er = tbl[i].er;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      chk({e.nm, ".state"}, state, e.st);
      chk({e.nm, ".mss"}, minsSecsOut, e.mss);
      chk({e.nm, ".wrtEn"}, wrtEn, e.wrt);
      chk({e.nm, ".decEn"}, decEn, e.dec);
      chk({e.nm, ".alarm"}, alarm, e.alm);
      chk({e.nm, ".err"}, err, e.er);
    end

    // 00:02 countdown into ALARM, then alarm hold/timeout
    drive(0, 0, 0, 1, 4'd2); step();
    chk("e2_entry", minsSecsOut, 16'h0002);
    drive(0, 1, 0, 0, 4'd0); step();
    drive(0, 0, 0, 0, 4'd0);
    dec1 = -1; dec2 = -1; ndec = 0; alm_at = -1; alm_cyc = 0;
    for (int c = 1; c <= 110; c++) begin
      if (decEn === 1'b1) begin
        ndec++;
        if (dec1 < 0) dec1 = c;
        else if (dec2 < 0) dec2 = c;
      end
      if (alarm === 1'b1) begin
        alm_cyc++;
        if (alm_at < 0) alm_at = c;
      end
      if (c < 110) step();
    end
    chk("e2_dec1_cycle", dec1, 5);
    chk("e2_dec2_cycle", dec2, 9);
    chk("e2_dec_count", ndec, 2);
    chk("e2_alarm_cycle", alm_at, 11);
    chk("e2_alarm_len", alm_cyc, EXP_ALARM_CYC);
    drive(0, 0, 1, 0, 4'd0); step();
    chk("alm_stop_state", state, ST_IDLE);
    chk("alm_stop_entry", minsSecsOut, 16'h0002);
    chk("alm_stop_alarm", alarm, 1'b0);
    drive(0, 1, 0, 0, 4'd0); step();
    chk("reload_state", state, ST_LOAD);
    chk("reload_wrt", wrtEn, 1'b1);
    drive(1, 0, 0, 0, 4'd0); step();
    chk("load_clr_state", state, ST_CLR);
    drive(0, 0, 0, 0, 4'd0); step();

    // Pause with prescaler at 2, resume, stop on a tick
    drive(0, 0, 0, 1, 4'd1); step();
    drive(0, 0, 0, 1, 4'd0); step();
    drive(0, 0, 0, 1, 4'd0); step();
    chk("p_entry", minsSecsOut, 16'h0100);
    drive(0, 1, 0, 0, 4'd0); step();
    drive(0, 0, 0, 0, 4'd0); step(); step(); step();
    chk("p_pre_state", state, ST_RUN);
    drive(0, 0, 1, 0, 4'd0); step();
    chk("p_pause_state", state, ST_PAUSE);
    drive(0, 0, 0, 0, 4'd0);
    pdec = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (decEn !== 1'b0) pdec++;
    end
    chk("p_paused_dec", pdec, 0);
    chk("p_paused_state", state, ST_PAUSE);
    chk("p_paused_cnt", cnt_q, 16'h0100);
    drive(0, 1, 0, 0, 4'd0); step();
    chk("p_resume_state", state, ST_RUN);
    chk("p_resume_dec", decEn, 1'b1);
    drive(0, 0, 1, 0, 4'd0); step();
    chk("tickstop_state", state, ST_PAUSE);
    chk("tickstop_cnt", cnt_q, 16'h0059);
    drive(0, 0, 1, 0, 4'd0); step();
    chk("stop_in_pause", state, ST_PAUSE);
    drive(0, 1, 0, 0, 4'd0); step();
    drive(0, 0, 0, 0, 4'd0);
    rdec = 0;
    for (int i = 0; i < 4; i++) begin
      if (decEn === 1'b1) rdec++;
      if (i < 3) step();
    end
    chk("wrap_last_dec", decEn, 1'b1);
    chk("wrap_dec_count", rdec, 1);

    // Reset in the middle of RUN
    reset = 1'b1; step();
    chk("mid_rst_state", state, ST_IDLE);
    chk("mid_rst_mss", minsSecsOut, 16'h0000);
    chk("mid_rst_wrt", wrtEn, 1'b0);
    chk("mid_rst_dec", decEn, 1'b0);
    reset = 1'b0; step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
